// File: rtl/thunderbird_pkg.sv
// rtl/thunderbird_pkg.sv - shared state encoding, lamp type and decode for the tail-light sequencer
package thunderbird_pkg;

  localparam int TICK_DIV_DEFAULT = 4;

  // IDLE must encode as zero so a cleared state register is a safe state.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L1   = 3'd1,
    L2   = 3'd2,
    L3   = 3'd3,
    R1   = 3'd4,
    R2   = 3'd5,
    R3   = 3'd6,
    HAZ  = 3'd7
  } state_t;

  // Lamp image in panel order: left inner..outer, then right inner..outer.
  typedef struct packed {
    logic la;
    logic lb;
    logic lc;
    logic ra;
    logic rb;
    logic rc;
  } lamps_t;

  function automatic logic is_left_seq(state_t st);
    return (st == L1) || (st == L2) || (st == L3);
  endfunction

  function automatic logic is_right_seq(state_t st);
    return (st == R1) || (st == R2) || (st == R3);
  endfunction

  // Sequence pattern for the state, then the brake fills every side that is
  // not currently running a turn sequence (HAZ is already fully lit).
  function automatic lamps_t decode_lamps(state_t st, logic brake);
    lamps_t lp;
    lp = '0;
    case (st)
      L1:  lp.la = 1'b1;
      L2:  begin lp.la = 1'b1; lp.lb = 1'b1; end
      L3:  begin lp.la = 1'b1; lp.lb = 1'b1; lp.lc = 1'b1; end
      R1:  lp.ra = 1'b1;
      R2:  begin lp.ra = 1'b1; lp.rb = 1'b1; end
      R3:  begin lp.ra = 1'b1; lp.rb = 1'b1; lp.rc = 1'b1; end
      HAZ: lp = '1;
      default: lp = '0;
    endcase
    if (brake) begin
      if (!is_left_seq(st)) begin
        lp.la = 1'b1;
        lp.lb = 1'b1;
        lp.lc = 1'b1;
      end
      if (!is_right_seq(st)) begin
        lp.ra = 1'b1;
        lp.rb = 1'b1;
        lp.rc = 1'b1;
      end
    end
    return lp;
  endfunction

endpackage

// File: rtl/thunderbird_if.sv
// rtl/thunderbird_if.sv - request and lamp signal bundle for the tail-light sequencer
interface thunderbird_if;

  // Requests toward the sequencer, already synchronized.
  logic B;
  logic L;
  logic R;
  logic H;

  // Lamp drives back from the sequencer.
  logic LA;
  logic LB;
  logic LC;
  logic RA;
  logic RB;
  logic RC;

  // Request source (driver side).
  modport master (
    output B, L, R, H,
    input  LA, LB, LC, RA, RB, RC
  );

  // Sequencer side.
  modport slave (
    input  B, L, R, H,
    output LA, LB, LC, RA, RB, RC
  );

endinterface

// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - free-running step counter producing one tick every TICK_DIV cycles
module tick_generator
  import thunderbird_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Count 0..TICK_DIV-1 and wrap; cleared while reset is low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // Tick is high for the single cycle the counter sits on its last value,
  // so the first tick edge after reset release is the TICK_DIV-th one.
  assign tick = (count == LAST);

endmodule

// File: rtl/thunderbird_fsm.sv
// rtl/thunderbird_fsm.sv - Thunderbird tail-light sequencer with brake overlay and hazard
module thunderbird_fsm
  import thunderbird_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic B,
  input  logic L,
  input  logic R,
  input  logic H,
  output logic LA,
  output logic LB,
  output logic LC,
  output logic RA,
  output logic RB,
  output logic RC
);

  logic   tick;
  logic   hz;
  state_t state_q;
  state_t state_d;
  lamps_t lamps_q;

  tick_generator #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Both turn requests together are treated exactly like the hazard switch.
  assign hz = H | (L & R);

  // State register; only moves when the next-state logic says so.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; requests are only looked at on a tick, otherwise hold.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (hz) begin
            state_d = HAZ;
          end else if (L) begin
            state_d = L1;
          end else if (R) begin
            state_d = R1;
          end else begin
            state_d = IDLE;
          end
        end
        L1:      state_d = hz ? HAZ : L2;
        L2:      state_d = hz ? HAZ : L3;
        L3:      state_d = hz ? HAZ : IDLE;
        R1:      state_d = hz ? HAZ : R2;
        R2:      state_d = hz ? HAZ : R3;
        R3:      state_d = hz ? HAZ : IDLE;
        HAZ:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Lamp register loads the decode of the upcoming state every cycle, so the
  // lamps move on the same edge as the state and track B one edge later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lamps_q <= '0;
    end else begin
      lamps_q <= decode_lamps(state_d, B);
    end
  end

  assign LA = lamps_q.la;
  assign LB = lamps_q.lb;
  assign LC = lamps_q.lc;
  assign RA = lamps_q.ra;
  assign RB = lamps_q.rb;
  assign RC = lamps_q.rc;

endmodule

// File: tb/tb_thunderbird_fsm.sv
// tb/tb_thunderbird_fsm.sv - self-checking bench for the tail-light sequencer
module tb_thunderbird_fsm;

  localparam int TD = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  // Reference model: which side is running (0 none, 1 left, 2 right, 3 hazard),
  // how many lamps of that side are lit, and cycles elapsed since reset.
  int       m_side;
  int       m_phase;
  int       m_cyc;
  logic [5:0] m_exp;

  thunderbird_if bus ();

  thunderbird_fsm #(
    .TICK_DIV (TD)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .B     (bus.B),
    .L     (bus.L),
    .R     (bus.R),
    .H     (bus.H),
    .LA    (bus.LA),
    .LB    (bus.LB),
    .LC    (bus.LC),
    .RA    (bus.RA),
    .RB    (bus.RB),
    .RC    (bus.RC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] lamps_now();
    return {bus.LA, bus.LB, bus.LC, bus.RA, bus.RB, bus.RC};
  endfunction

  task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // n lamps lit from the inner lamp outward, as a 3-bit inner..outer image.
  function automatic logic [2:0] bar(input int n);
    int v;
    v = (7 << (3 - n)) & 7;
    return v[2:0];
  endfunction

  task automatic model_reset();
    m_side  = 0;
    m_phase = 0;
    m_cyc   = 0;
    m_exp   = '0;
  endtask

  // One rising edge of the reference: every TD-th edge after reset is a step.
  task automatic model_edge();
    logic hz;
    logic [2:0] lft;
    logic [2:0] rgt;
    m_cyc++;
    if (m_cyc % TD == 0) begin
      hz = bus.H | (bus.L & bus.R);
      if (m_side == 3) begin
        m_side = 0;
      end else if (m_side == 0) begin
        if (hz)         m_side = 3;
        else if (bus.L) begin m_side = 1; m_phase = 1; end
        else if (bus.R) begin m_side = 2; m_phase = 1; end
      end else if (hz) begin
        m_side = 3;
      end else begin
        m_phase++;
        if (m_phase > 3) m_side = 0;
      end
    end
    lft = (m_side == 1) ? bar(m_phase) : 3'b000;
    rgt = (m_side == 2) ? bar(m_phase) : 3'b000;
    if (m_side == 3) begin
      lft = 3'b111;
      rgt = 3'b111;
    end
    if (bus.B && m_side != 1) lft = 3'b111;
    if (bus.B && m_side != 2) rgt = 3'b111;
    m_exp = {lft, rgt};
  endtask

  task automatic set_in(input logic b, input logic l, input logic r, input logic h);
    bus.B = b;
    bus.L = l;
    bus.R = r;
    bus.H = h;
  endtask

  // Advance one edge, update the model, and compare 2 time units later.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #2;
    check_eq("lamps", lamps_now(), m_exp);
  endtask

  // Assert reset between edges, confirm the lamps clear without a clock edge,
  // hold one edge, then release mid-cycle so the next edge is edge 1.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("reset_async", lamps_now(), 6'b000000);
    model_reset();
    step();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    check_eq("reset_state", lamps_now(), 6'b000000);
    rst_n = 1'b1;

    // Left sequence with L held from release.
    do_reset();
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      step();
      case (e)
        4:  check_eq("left_e4",  lamps_now(), 6'b100000);
        8:  check_eq("left_e8",  lamps_now(), 6'b110000);
        12: check_eq("left_e12", lamps_now(), 6'b111000);
        16: check_eq("left_e16", lamps_now(), 6'b000000);
        20: check_eq("left_e20", lamps_now(), 6'b100000);
        default: ;
      endcase
    end

    // Sustained hazard blinks each tick.
    do_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b1);
    for (int e = 1; e <= 16; e++) begin
      step();
      if (e == 4)  check_eq("haz_e4",  lamps_now(), 6'b111111);
      if (e == 8)  check_eq("haz_e8",  lamps_now(), 6'b000000);
      if (e == 12) check_eq("haz_e12", lamps_now(), 6'b111111);
      if (e == 16) check_eq("haz_e16", lamps_now(), 6'b000000);
    end

    // L and R together act as hazard.
    do_reset();
    set_in(1'b0, 1'b1, 1'b1, 1'b0);
    for (int e = 1; e <= 4; e++) step();
    check_eq("lr_haz", lamps_now(), 6'b111111);

    // Brake during right turn.
    do_reset();
    set_in(1'b1, 1'b0, 1'b1, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 4)  check_eq("brk_r1", lamps_now(), 6'b111100);
      if (e == 8)  check_eq("brk_r2", lamps_now(), 6'b111110);
      if (e == 12) check_eq("brk_r3", lamps_now(), 6'b111111);
    end

    // Brake alone shows one edge after it is sampled.
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("brk_pre", lamps_now(), 6'b000000);
    step();
    check_eq("brk_edge1", lamps_now(), 6'b111111);

    // Hazard overrides a running left sequence at L2.
    do_reset();
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 8; e++) step();
    check_eq("ovr_l2", lamps_now(), 6'b110000);
    set_in(1'b0, 1'b1, 1'b0, 1'b1);
    for (int e = 1; e <= 4; e++) step();
    check_eq("ovr_haz", lamps_now(), 6'b111111);

    // Reset in L3 aborts at once; restart steps 4 edges after release.
    do_reset();
    set_in(1'b0, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 12; e++) step();
    check_eq("mid_l3", lamps_now(), 6'b111000);
    do_reset();
    for (int e = 1; e <= 4; e++) begin
      step();
      if (e == 3) check_eq("restart_e3", lamps_now(), 6'b000000);
      if (e == 4) check_eq("restart_e4", lamps_now(), 6'b100000);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      if ($urandom_range(0, 2) == 0) begin
        set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/thunderbird_fsm.md
THUNDERBIRD_FSM -- requirements
Module: thunderbird_fsm

Interface
REQ-001 Parameter TICK_DIV, default 4: clock cycles per sequencing step, legal range 2..65535.
REQ-002 The clock and reset ports SHALL be exactly as listed below.
- clock  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
REQ-003 The data ports SHALL be:
- B  input  1  brake request, already synchronized upstream.
- L  input  1  left-turn request, synchronized.
- R  input  1  right-turn request, synchronized.
- H  input  1  hazard request, synchronized.
- LA, LB, LC  output  1 each  left lamps, inner to outer.
- RA, RB, RC  output  1 each  right lamps, inner to outer.

Function
REQ-004 An internal step counter SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-005 A one-cycle tick SHALL be asserted when the counter equals TICK_DIV-1, giving exactly one tick per TICK_DIV cycles.
REQ-006 The FSM state SHALL change only on a cycle where tick=1; it SHALL hold on all other cycles.
REQ-007 The FSM SHALL have eight states: IDLE, L1, L2, L3, R1, R2, R3, HAZ.
REQ-008 A hazard condition, hz, SHALL be defined as H | (L & R).
REQ-009 Transitions from IDLE, evaluated on tick:
- hz -> HAZ
- else L -> L1
- else R -> R1
- else stay in IDLE.
REQ-010 The left sequence SHALL run L1 -> L2 -> L3 -> IDLE regardless of L, unless hz is true at the tick; then go to HAZ.
REQ-011 The right sequence SHALL behave the same way: R1 -> R2 -> R3 -> IDLE, unless hz at the tick, then HAZ.
REQ-012 HAZ SHALL always go to IDLE on the next tick, so a sustained hazard blinks on and off each tick.
REQ-013 Lamp decode per state:
- L1 = LA
- L2 = LA, LB
- L3 = LA, LB, LC
- R1, R2, R3 mirror L1, L2, L3 on RA, RB, RC
- HAZ = all six lamps on
- IDLE = all lamps off.
REQ-014 Brake overlay when B=1:
- The side not being sequenced SHALL show all three lamps on.
- In IDLE, both sides SHALL be all on.
- HAZ stays all on.
- The sequencing side SHALL keep its sequence pattern.
REQ-015 Outputs SHALL be registered: the output register loads decode(next_state, B) every cycle, so lamps change on the same edge as the state.
REQ-016 A change on B SHALL appear on the lamps exactly one clock edge after it is sampled.
REQ-017 Simultaneous L and R with H=0 SHALL be treated as hazard.
REQ-018 A change on L, R or H between ticks SHALL have no effect until the next tick.

Reset
REQ-019 While reset=0, asynchronously:
- state = IDLE
- step counter = 0
- all six lamp outputs = 0.
REQ-020 Reset asserted mid-sequence SHALL abort the sequence immediately.
REQ-021 After reset release, the first tick SHALL occur on the TICK_DIV-th rising edge.
REQ-022 No output SHALL glitch high on the reset release edge.

Structure
REQ-023 Package thunderbird_pkg SHALL hold:
- the state encoding constants (3-bit, IDLE=0)
- the default TICK_DIV.
REQ-024 The step counter and tick SHALL live in sub-module tick_generator, parameterized by TICK_DIV, with output tick.
REQ-025 thunderbird_fsm SHALL instantiate tick_generator once.

Verification
REQ-026 Left sequence: TICK_DIV=4; hold L=1 from reset release -> lamp patterns at edges 4, 8, 12, 16, 20:
- LA
- LA+LB
- LA+LB+LC
- off
- LA
- R lamps stay 0 throughout.
REQ-027 Hazard: H=1 for 16 cycles -> all six lamps on at edge 4, off at 8, on at 12, off at 16.
REQ-028 Brake during right turn: R=1 and B=1 -> RA..RC follow R1/R2/R3 and LA=LB=LC=1 throughout; B=1 alone -> all six on one edge after B is sampled.
REQ-029 Hazard override: L=1 sequence reaches L2, then H=1 -> HAZ at the next tick, not L3.
REQ-030 Reset mid-op: reset=0 asserted between ticks while in L3 -> all lamps 0 immediately, without waiting for a clock edge.
REQ-031 Restart after reset: after release from REQ-030, the first state change occurs exactly 4 edges later.
